// File: rtl/proc_control_if.sv
// Datapath-facing bundle of the proc_control sequencer: run/instruction inputs and
// every enable, select and status strobe the control unit drives.
interface proc_control_if;
    logic        Run;
    logic [15:0] DIN;
    logic        IRin;
    logic [7:0]  Rin;
    logic [7:0]  Rout;
    logic        DINout;
    logic        Ain;
    logic        Gin;
    logic        Gout;
    logic [3:0]  aluSignal;
    logic        Done;

    modport master (
        output Run, DIN,
        input  IRin, Rin, Rout, DINout, Ain, Gin, Gout, aluSignal, Done
    );

    modport slave (
        input  Run, DIN,
        output IRin, Rin, Rout, DINout, Ain, Gin, Gout, aluSignal, Done
    );
endinterface

// File: rtl/proc_control.sv
// Multi-cycle control unit (T0..T3) that latches instructions from DIN and sequences the datapath.
// Optional build macro PROC_CONTROL_ILLEGAL_TRAP_EN adds a sticky Illegal flag and a HALT state.
module proc_control #(
    parameter int OPW  = 4,
    parameter int NREG = 8
) (
    input  logic           Clock,
    input  logic           Resetn,
    proc_control_if.slave  bus
`ifdef PROC_CONTROL_ILLEGAL_TRAP_EN
    ,
    output logic           Illegal
`endif
);

    localparam logic [OPW-1:0] OP_MV  = 4'b0000;
    localparam logic [OPW-1:0] OP_MVI = 4'b0001;
    localparam logic [OPW-1:0] OP_ADD = 4'b0010;
    localparam logic [OPW-1:0] OP_SUB = 4'b0011;
    localparam logic [OPW-1:0] OP_OR  = 4'b0100;
    localparam logic [OPW-1:0] OP_SLT = 4'b0101;
    localparam logic [OPW-1:0] OP_SLL = 4'b0110;
    localparam logic [OPW-1:0] OP_SRL = 4'b0111;

    typedef enum logic [2:0] {
        ST_T0   = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
`ifdef PROC_CONTROL_ILLEGAL_TRAP_EN
        ST_T3   = 3'd3,
        ST_HALT = 3'd4
`else
        ST_T3   = 3'd3
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [OPW-1:0] opcode_s;
    logic [2:0]     rx_s;
    logic [2:0]     ry_s;
    logic           unused_ir_s;

    logic            irin_s;
    logic [NREG-1:0] rin_s;
    logic [NREG-1:0] rout_s;
    logic            dinout_s;
    logic            ain_s;
    logic            gin_s;
    logic            gout_s;
    logic [3:0]      alu_s;
    logic            done_s;
    logic            illegal_set_s;

    function automatic logic [NREG-1:0] onehot(input logic [2:0] idx);
        logic [NREG-1:0] v;
        v      = {NREG{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [3:0] alu_code(input logic [OPW-1:0] opc);
        logic [3:0] c;
        case (opc)
            OP_ADD:  c = 4'b0000;
            OP_SUB:  c = 4'b0001;
            OP_OR:   c = 4'b0010;
            OP_SLT:  c = 4'b0011;
            OP_SLL:  c = 4'b0100;
            OP_SRL:  c = 4'b0101;
            default: c = 4'b0000;
        endcase
        return c;
    endfunction

    assign opcode_s    = ir_q[15:16-OPW];
    assign rx_s        = ir_q[11:9];
    assign ry_s        = ir_q[8:6];
    assign unused_ir_s = ^ir_q[5:0];

    // Next-state and output decode from current state and latched instruction
    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        irin_s        = 1'b0;
        rin_s         = {NREG{1'b0}};
        rout_s        = {NREG{1'b0}};
        dinout_s      = 1'b0;
        ain_s         = 1'b0;
        gin_s         = 1'b0;
        gout_s        = 1'b0;
        alu_s         = 4'b0000;
        done_s        = 1'b0;
        illegal_set_s = 1'b0;
        case (state_q)
            ST_T0: begin
                // IRin must stay low while reset is held, even with Run high
                irin_s = bus.Run & Resetn;
                if (bus.Run) begin
                    ir_d    = bus.DIN;
                    state_d = ST_T1;
                end else begin
                    state_d = ST_T0;
                end
            end
            ST_T1: begin
                case (opcode_s)
                    OP_MV: begin
                        rout_s  = onehot(ry_s);
                        rin_s   = onehot(rx_s);
                        done_s  = 1'b1;
                        state_d = ST_T0;
                    end
                    OP_MVI: begin
                        dinout_s = 1'b1;
                        rin_s    = onehot(rx_s);
                        done_s   = 1'b1;
                        state_d  = ST_T0;
                    end
                    OP_ADD, OP_SUB, OP_OR, OP_SLT, OP_SLL, OP_SRL: begin
                        rout_s  = onehot(rx_s);
                        ain_s   = 1'b1;
                        state_d = ST_T2;
                    end
                    default: begin
`ifdef PROC_CONTROL_ILLEGAL_TRAP_EN
                        illegal_set_s = 1'b1;
                        state_d       = ST_HALT;
`else
                        done_s  = 1'b1;
                        state_d = ST_T0;
`endif
                    end
                endcase
            end
            ST_T2: begin
                rout_s  = onehot(ry_s);
                gin_s   = 1'b1;
                alu_s   = alu_code(opcode_s);
                state_d = ST_T3;
            end
            ST_T3: begin
                gout_s  = 1'b1;
                rin_s   = onehot(rx_s);
                done_s  = 1'b1;
                state_d = ST_T0;
            end
`ifdef PROC_CONTROL_ILLEGAL_TRAP_EN
            ST_HALT: begin
                state_d = ST_HALT;
            end
`endif
            default: begin
                state_d = ST_T0;
            end
        endcase
    end

    // State and instruction register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_T0;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

`ifdef PROC_CONTROL_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky illegal-opcode flag, cleared only by reset
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_q | illegal_set_s;
        end
    end

    assign Illegal = illegal_q | illegal_set_s;
`else
    logic unused_illegal_s;
    assign unused_illegal_s = illegal_set_s;
`endif

    assign bus.IRin      = irin_s;
    assign bus.Rin       = rin_s;
    assign bus.Rout      = rout_s;
    assign bus.DINout    = dinout_s;
    assign bus.Ain       = ain_s;
    assign bus.Gin       = gin_s;
    assign bus.Gout      = gout_s;
    assign bus.aluSignal = alu_s;
    assign bus.Done      = done_s;

endmodule

// File: tb/tb_proc_control.sv
// Scoreboard bench for proc_control: each issued cycle pushes its expected outputs,
// derived instruction by instruction; a negedge monitor pops and compares.
module tb_proc_control;

    logic Clock  = 1'b0;
    logic Resetn = 1'b0;
    proc_control_if bus ();

`ifdef PROC_CONTROL_ILLEGAL_TRAP_EN
    logic Illegal;
    proc_control dut (.Clock(Clock), .Resetn(Resetn), .bus(bus), .Illegal(Illegal));
`else
    proc_control dut (.Clock(Clock), .Resetn(Resetn), .bus(bus));
`endif

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic       ill;
        logic       irin;
        logic [7:0] rin;
        logic [7:0] rout;
        logic       dinout;
        logic       ain;
        logic       gin;
        logic       gout;
        logic [3:0] alu;
        logic       done;
    } out_t;

    out_t  exp_q[$];
    string name_q[$];
    int    tests  = 0;
    int    failed = 0;
    logic  ill_m  = 1'b0;

    // Monitor: compare the whole output vector against the oldest expectation
    always @(negedge Clock) begin
        out_t  act;
        out_t  ex;
        string nm;
        if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            nm = name_q.pop_front();
`ifdef PROC_CONTROL_ILLEGAL_TRAP_EN
            act.ill = Illegal;
`else
            act.ill = 1'b0;
`endif
            act.irin   = bus.IRin;
            act.rin    = bus.Rin;
            act.rout   = bus.Rout;
            act.dinout = bus.DINout;
            act.ain    = bus.Ain;
            act.gin    = bus.Gin;
            act.gout   = bus.Gout;
            act.alu    = bus.aluSignal;
            act.done   = bus.Done;
            tests++;
            if (act !== ex) begin
                failed++;
                $display("FAIL %s @%0t: got ill=%b irin=%b rin=%h rout=%h dinout=%b ain=%b gin=%b gout=%b alu=%b done=%b, expected ill=%b irin=%b rin=%h rout=%h dinout=%b ain=%b gin=%b gout=%b alu=%b done=%b",
                         nm, $time, act.ill, act.irin, act.rin, act.rout, act.dinout, act.ain, act.gin, act.gout, act.alu, act.done,
                         ex.ill, ex.irin, ex.rin, ex.rout, ex.dinout, ex.ain, ex.gin, ex.gout, ex.alu, ex.done);
            end
        end
    end

    function automatic out_t zero_out();
        out_t e;
        e     = '0;
        e.ill = ill_m;
        return e;
    endfunction

    // One clock cycle: drive inputs, record expectation, advance to just after the next edge
    task automatic step(input out_t e, input string nm, input logic run, input logic [15:0] din);
        bus.Run = run;
        bus.DIN = din;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(zero_out(), "idle", 1'b0, 16'($urandom));
    endtask

    // Expand one instruction into its expected per-cycle outputs
    task automatic issue(input logic [15:0] ir, input logic [15:0] imm, input logic hold_run);
        logic [3:0] opc;
        int         rx;
        int         ry;
        out_t       e;
        logic       r;
        opc = ir[15:12];
        rx  = int'(ir[11:9]);
        ry  = int'(ir[8:6]);
        e = zero_out();
        e.irin = 1'b1;
        step(e, "T0", 1'b1, ir);
        r = hold_run ? 1'b1 : 1'($urandom);
        e = zero_out();
        if (opc == 4'd0) begin
            e.rout = 8'd1 << ry; e.rin = 8'd1 << rx; e.done = 1'b1;
            step(e, "T1_mv", r, imm);
        end else if (opc == 4'd1) begin
            e.dinout = 1'b1; e.rin = 8'd1 << rx; e.done = 1'b1;
            step(e, "T1_mvi", r, imm);
        end else if (opc <= 4'd7) begin
            e.rout = 8'd1 << rx; e.ain = 1'b1;
            step(e, "T1_alu", r, imm);
            e = zero_out();
            e.rout = 8'd1 << ry; e.gin = 1'b1; e.alu = opc - 4'd2;
            step(e, "T2_alu", hold_run ? 1'b1 : 1'($urandom), 16'($urandom));
            e = zero_out();
            e.gout = 1'b1; e.rin = 8'd1 << rx; e.done = 1'b1;
            step(e, "T3_alu", hold_run ? 1'b1 : 1'($urandom), 16'($urandom));
        end else begin
`ifdef PROC_CONTROL_ILLEGAL_TRAP_EN
            e.ill = 1'b1;
            ill_m = 1'b1;
`else
            e.done = 1'b1;
`endif
            step(e, "T1_illegal", r, imm);
        end
    endtask

    task automatic reset_release();
        bus.Run = 1'b0;
        Resetn  = 1'b1;
        ill_m   = 1'b0;
        step(zero_out(), "post_reset", 1'b0, 16'($urandom));
    endtask

    initial begin
        out_t e;
        bus.Run = 1'b0;
        bus.DIN = 16'h0000;
        @(posedge Clock);
        #1;
        // Reset held with Run high: IRin must stay gated
        step(zero_out(), "reset_idle", 1'b1, 16'h1200);
        reset_release();

        issue(16'h1200, 16'h0005, 1'b0);
        issue(16'h2280, 16'h0000, 1'b0);
        idle(1);
        issue(16'h7040, 16'h0000, 1'b0);
        issue(16'h5040, 16'h0000, 1'b0);
        idle(2);
        issue(16'h0700, 16'h0000, 1'b1);
        issue(16'h3EC0, 16'h0000, 1'b1);
        idle(1);

        // Asynchronous reset in the middle of T2 of an add
        e = zero_out(); e.irin = 1'b1;
        step(e, "rst_T0", 1'b1, 16'h2280);
        e = zero_out(); e.rout = 8'h02; e.ain = 1'b1;
        step(e, "rst_T1", 1'b0, 16'h0000);
        bus.Run = 1'b1;
        #1 Resetn = 1'b0;
        #1;
        tests++;
        if (bus.Rin !== 8'h00 || bus.Rout !== 8'h00 || bus.Gin !== 1'b0 || bus.Ain !== 1'b0 ||
            bus.Gout !== 1'b0 || bus.DINout !== 1'b0 || bus.Done !== 1'b0 || bus.IRin !== 1'b0 ||
            bus.aluSignal !== 4'b0000) begin
            failed++;
            $display("FAIL async_reset @%0t: outputs not zero immediately after Resetn fell", $time);
        end
        step(zero_out(), "rst_midT2", 1'b1, 16'h2280);
        step(zero_out(), "rst_held", 1'b1, 16'h2280);
        reset_release();
        idle(2);

        issue(16'hF000, 16'h0000, 1'b0);
`ifdef PROC_CONTROL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) step(zero_out(), "halt", 1'b1, 16'h1200);
        Resetn = 1'b0;
        step(zero_out(), "halt_reset", 1'b0, 16'h0000);
        reset_release();
`endif
        issue(16'h1200, 16'h0005, 1'b0);

        for (int n = 0; n < 300; n++) begin
            logic [15:0] ir;
            ir = 16'($urandom);
`ifdef PROC_CONTROL_ILLEGAL_TRAP_EN
            ir[15] = 1'b0;
`endif
            issue(ir, 16'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        idle(1);
        @(negedge Clock);
        #1;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d expectations never compared", exp_q.size());
        end
        if (tests < 600) begin
            failed++;
            $display("FAIL coverage: only %0d comparisons ran", tests);
        end
        if (failed != 0) begin
            $display("[TB] FAILED");
        end else begin
            $display("[TB] PASSED");
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
